// File: rtl/prime_pkg.sv
// Shared definitions for the prime scanner and its checker bench.
// The scan controller states and the default number width live here.
package prime_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        AWAIT = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/prime_cand_counter.sv
// Candidate counter for the prime scanner: holds the current candidate and
// the upper bound, steps through the range and flags the end of the range.
// Optional feature macro: PRIME_SCANNER_SKIP_EVEN_EN -- when defined, values
// below 2 and even values other than 2 are flagged for local rejection.
module prime_cand_counter
    import prime_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] cand,
    output logic             at_end,
    output logic             skip
);

    logic [WIDTH-1:0] hi_q;

    // Candidate and bound registers; stepping stops at the bound so the
    // candidate never wraps past all-ones.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            cand <= '0;
            hi_q <= '0;
        end else if (load) begin
            cand <= lo;
            hi_q <= hi;
        end else if (step && !at_end) begin
            cand <= cand + WIDTH'(1);
        end
    end

    // End-of-range test is made on the un-incremented candidate.
    always_comb begin
        at_end = (cand == hi_q);
    end

    // Local rejection of obviously composite candidates.
    always_comb begin
`ifdef PRIME_SCANNER_SKIP_EVEN_EN
        skip = (cand < WIDTH'(2)) || (!cand[0] && (cand != WIDTH'(2)));
`else
        skip = 1'b0;
`endif
    end

endmodule

// File: rtl/prime_scanner.sv
// Prime scanner: walks an inclusive range [lo, hi], offers each candidate to
// an external prime checker one at a time, and streams out the primes found
// together with a running count and a one-cycle done pulse.
// Optional feature macro: PRIME_SCANNER_SKIP_EVEN_EN (see prime_cand_counter).
module prime_scanner
    import prime_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [WIDTH-1:0] req_number,
    input  logic             rsp_valid,
    output logic             rsp_ready,
    input  logic             rsp_result,
    output logic             prime_valid,
    input  logic             prime_ready,
    output logic [WIDTH-1:0] prime_number,
    output logic [WIDTH-1:0] prime_count,
    output logic             done
);

    state_t           state_q;
    state_t           state_d;
    logic             load;
    logic             step;
    logic             capture;
    logic             count_inc;
    logic [WIDTH-1:0] cand;
    logic             at_end;
    logic             skip;

    prime_cand_counter #(
        .WIDTH (WIDTH)
    ) u_cand (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .lo     (lo),
        .hi     (hi),
        .cand   (cand),
        .at_end (at_end),
        .skip   (skip)
    );

    assign req_number = cand;

    // State register; reset wins from any state, dropping an in-flight verdict.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and Moore outputs; advancing ends the scan at the bound.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d     = state_q;
        cmd_ready   = 1'b0;
        req_valid   = 1'b0;
        rsp_ready   = 1'b0;
        prime_valid = 1'b0;
        done        = 1'b0;
        load        = 1'b0;
        step        = 1'b0;
        capture     = 1'b0;
        count_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    load    = 1'b1;
                    state_d = (lo <= hi) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (skip) begin
                    step    = 1'b1;
                    state_d = at_end ? DONE : ISSUE;
                end else begin
                    req_valid = 1'b1;
                    if (req_ready) state_d = AWAIT;
                end
            end
            AWAIT: begin
                rsp_ready = 1'b1;
                if (rsp_valid) begin
                    if (rsp_result) begin
                        capture = 1'b1;
                        state_d = EMIT;
                    end else begin
                        step    = 1'b1;
                        state_d = at_end ? DONE : ISSUE;
                    end
                end
            end
            EMIT: begin
                prime_valid = 1'b1;
                if (prime_ready) begin
                    count_inc = 1'b1;
                    step      = 1'b1;
                    state_d   = at_end ? DONE : ISSUE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output prime value and count; the count holds until the next command.
    always_ff @(posedge clk) begin
        // NOTE: only control/status registers are reset; there is no memory here.
        if (rst) begin
            prime_number <= '0;
            prime_count  <= '0;
        end else begin
            if (capture)   prime_number <= cand;
            if (load)      prime_count  <= '0;
            else if (count_inc) prime_count <= prime_count + WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_prime_scanner.sv
// Directed bench for prime_scanner: a 32-bit and an 8-bit instance share
// stimulus; a behavioural prime checker answers requests.
// Optional feature macro: PRIME_SCANNER_SKIP_EVEN_EN changes expected requests.
module tb_prime_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel8;
    logic        cmd_valid, req_ready, rsp_valid, rsp_result, prime_ready;
    logic [31:0] lo, hi;

    logic        a_cmd_ready, a_req_valid, a_rsp_ready, a_prime_valid, a_done;
    logic [31:0] a_req_number, a_prime_number, a_prime_count;
    logic        b_cmd_ready, b_req_valid, b_rsp_ready, b_prime_valid, b_done;
    logic [7:0]  b_req_number, b_prime_number, b_prime_count;

    logic        cmd_ready_m, req_valid_m, rsp_ready_m, prime_valid_m, done_m;
    logic [31:0] req_number_m, prime_number_m, prime_count_m;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] q_req[$];
    logic [31:0] q_prime[$];
    int          n_done;
    int          done_cyc;
    int          first_req_cyc;

    always #5 clk = ~clk;

    prime_scanner #(.WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid && !sel8), .cmd_ready(a_cmd_ready),
        .lo(lo), .hi(hi), .req_valid(a_req_valid), .req_ready(req_ready),
        .req_number(a_req_number), .rsp_valid(rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_result(rsp_result), .prime_valid(a_prime_valid), .prime_ready(prime_ready),
        .prime_number(a_prime_number), .prime_count(a_prime_count), .done(a_done)
    );

    prime_scanner #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid && sel8), .cmd_ready(b_cmd_ready),
        .lo(lo[7:0]), .hi(hi[7:0]), .req_valid(b_req_valid), .req_ready(req_ready),
        .req_number(b_req_number), .rsp_valid(rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_result(rsp_result), .prime_valid(b_prime_valid), .prime_ready(prime_ready),
        .prime_number(b_prime_number), .prime_count(b_prime_count), .done(b_done)
    );

    always_comb begin
        cmd_ready_m    = sel8 ? b_cmd_ready   : a_cmd_ready;
        req_valid_m    = sel8 ? b_req_valid   : a_req_valid;
        rsp_ready_m    = sel8 ? b_rsp_ready   : a_rsp_ready;
        prime_valid_m  = sel8 ? b_prime_valid : a_prime_valid;
        done_m         = sel8 ? b_done        : a_done;
        req_number_m   = sel8 ? {24'd0, b_req_number}   : a_req_number;
        prime_number_m = sel8 ? {24'd0, b_prime_number} : a_prime_number;
        prime_count_m  = sel8 ? {24'd0, b_prime_count}  : a_prime_count;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic is_prime(input logic [31:0] n);
        if (n < 2) return 1'b0;
        for (longint d = 2; d * d <= longint'(n); d++)
            if (longint'(n) % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_reset_vals(input string where);
        check({where, "_cmd_ready"},    {31'd0, cmd_ready_m},   1);
        check({where, "_req_valid"},    {31'd0, req_valid_m},   0);
        check({where, "_rsp_ready"},    {31'd0, rsp_ready_m},   0);
        check({where, "_prime_valid"},  {31'd0, prime_valid_m}, 0);
        check({where, "_done"},         {31'd0, done_m},        0);
        check({where, "_req_number"},   req_number_m,           0);
        check({where, "_prime_number"}, prime_number_m,         0);
        check({where, "_prime_count"},  prime_count_m,          0);
    endtask

    // One scan: issue the command, then act as checker and sink each cycle.
    // stall holds off the first prime; abort_at resets mid-AWAIT on that value.
    task automatic run_scan(input logic sel, input logic [31:0] lo_v, input logic [31:0] hi_v,
                            input int stall, input logic [31:0] stall_val,
                            input logic [31:0] abort_at);
        logic        have_pend = 1'b0;
        logic [31:0] pend_val  = '0;
        int          stall_left = stall;
        logic        fin = 1'b0;
        q_req.delete();
        q_prime.delete();
        n_done = 0;
        done_cyc = -1;
        first_req_cyc = -1;
        @(negedge clk);
        sel8 = sel;
        lo = lo_v;
        hi = hi_v;
        #1 check("cmd_ready_before_cmd", {31'd0, cmd_ready_m}, 1);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (done_m) begin
                n_done++;
                done_cyc = cyc;
                req_ready = 1'b0; rsp_valid = 1'b0; prime_ready = 1'b0;
                @(negedge clk);
                check("done_one_cycle", {31'd0, done_m}, 0);
                check("idle_after_done", {31'd0, cmd_ready_m}, 1);
                fin = 1'b1;
            end else if (rsp_ready_m && have_pend && pend_val == abort_at) begin
                rst = 1'b1;
                rsp_valid = 1'b0;
                @(negedge clk);
                check_reset_vals("abort");
                rst = 1'b0;
                rsp_valid = 1'b1;
                rsp_result = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("abort_rsp_ignored_pv", {31'd0, prime_valid_m}, 0);
                    check("abort_rsp_ignored_cr", {31'd0, cmd_ready_m}, 1);
                end
                rsp_valid = 1'b0;
                rsp_result = 1'b0;
                fin = 1'b1;
            end else begin
                req_ready = 1'b1;
                if (req_valid_m) begin
                    q_req.push_back(req_number_m);
                    if (first_req_cyc < 0) first_req_cyc = cyc;
                    have_pend = 1'b1;
                    pend_val = req_number_m;
                end
                if (rsp_ready_m && have_pend) begin
                    rsp_valid = 1'b1;
                    rsp_result = is_prime(pend_val);
                    have_pend = 1'b0;
                end else begin
                    rsp_valid = 1'b0;
                    rsp_result = 1'b0;
                end
                prime_ready = 1'b0;
                if (prime_valid_m) begin
                    if (stall_left > 0) begin
                        check("stall_prime_number", prime_number_m, stall_val);
                        check("stall_req_valid", {31'd0, req_valid_m}, 0);
                        stall_left--;
                    end else begin
                        prime_ready = 1'b1;
                        q_prime.push_back(prime_number_m);
                    end
                end
                @(negedge clk);
            end
        end
        if (!fin) check("scan_timeout", 0, 1);
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_result = 1'b0; prime_ready = 1'b0;
    endtask

    task automatic check_list(input string tag, input logic [31:0] got[$], input logic [31:0] exp[$]);
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            check(tag, got[i], exp[i]);
    endtask

    initial begin
        logic [31:0] exp[$];
        rst = 1'b1; sel8 = 1'b0; cmd_valid = 1'b0; req_ready = 1'b0;
        rsp_valid = 1'b0; rsp_result = 1'b0; prime_ready = 1'b0; lo = '0; hi = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset32");
        sel8 = 1'b1;
        #1 check_reset_vals("reset8");
        sel8 = 1'b0;
        rst = 1'b0;

        // Range 2..20, free-flowing sink.
        run_scan(1'b0, 2, 20, 0, 0, 32'hFFFF_FFFF);
        exp = '{2, 3, 5, 7, 11, 13, 17, 19};
        check_list("r20_primes", q_prime, exp);
        check("r20_count", prime_count_m, 8);
        check("r20_done_pulses", n_done, 1);
        check("r20_first_req_cycle", first_req_cyc, 0);
`ifdef PRIME_SCANNER_SKIP_EVEN_EN
        check("r20_requests", q_req.size(), 10);
`else
        check("r20_requests", q_req.size(), 19);
`endif

        // Empty range lo > hi.
        run_scan(1'b0, 10, 5, 0, 0, 32'hFFFF_FFFF);
        check("empty_done_cycle", done_cyc, 0);
        check("empty_requests", q_req.size(), 0);
        check("empty_count", prime_count_m, 0);
        check("empty_done_pulses", n_done, 1);

        // Range 2..10 with the first prime stalled for 10 cycles.
        run_scan(1'b0, 2, 10, 10, 2, 32'hFFFF_FFFF);
        exp = '{2, 3, 5, 7};
        check_list("stall_primes", q_prime, exp);
        check("stall_count", prime_count_m, 4);
`ifdef PRIME_SCANNER_SKIP_EVEN_EN
        exp = '{2, 3, 5, 7, 9};
`else
        exp = '{2, 3, 4, 5, 6, 7, 8, 9, 10};
`endif
        check_list("r10_requests", q_req, exp);

        // 8-bit instance at the top of its range.
        run_scan(1'b1, 250, 255, 0, 0, 32'hFFFF_FFFF);
        exp = '{251};
        check_list("w8_primes", q_prime, exp);
        check("w8_count", prime_count_m, 1);
        check("w8_done_pulses", n_done, 1);
`ifdef PRIME_SCANNER_SKIP_EVEN_EN
        exp = '{251, 253, 255};
`else
        exp = '{250, 251, 252, 253, 254, 255};
`endif
        check_list("w8_requests", q_req, exp);
        sel8 = 1'b0;

        // Reset while waiting on the verdict for 7.
        run_scan(1'b0, 2, 10, 0, 0, 7);
        exp = '{2, 3, 5};
        check_list("abort_primes_before", q_prime, exp);

        // Recovery scan after the abort.
        run_scan(1'b0, 3, 6, 0, 0, 32'hFFFF_FFFF);
        exp = '{3, 5};
        check_list("recover_primes", q_prime, exp);
        check("recover_count", prime_count_m, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
